vector_dmem_resp: RTL and testbench

VECTOR_DMEM_RESP -- requirements
Module: vector_dmem_resp

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_lane_bank.sv | 25 ++
 rtl/vector_dmem_resp.sv | 131 +++++++++++++
 tb/tb_vector_dmem_resp.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the vector data-memory responder.
package dmem_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int DATA_W = LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_bank.sv
// One 32-bit lane of the data memory: synchronous write, registered read.
// The read register only updates when re is high, so it holds its value
// for as long as the response is pending.
module dmem_lane_bank
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LANE_W-1:0] wdata,
  output logic [LANE_W-1:0] rdata
);

  logic [LANE_W-1:0] mem [2**ADDR_W];

  // Lane storage write and held read port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/vector_dmem_resp.sv
// Vector data-memory responder: one outstanding 256-bit load/store with a
// fixed read latency and a valid/ready response handshake.
// Optional build macro: DMEM_PARITY_EN (per-lane even parity on loads).
module vector_dmem_resp
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W:0]   req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LANES-1:0]  req_lane_en,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        is_store;
  logic        addr_err;
  logic        accept;
  logic        wr_en;
  logic        par_err;
  logic [DATA_W-1:0] bank_q;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_we && !req_addr[ADDR_W];

  // The lane RAMs are read at the acceptance edge, which both captures the
  // address and makes the data ready in time for RD_LAT = 1.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dmem_lane_bank #(.ADDR_W(ADDR_W)) u_bank (
      .clk   (clk),
      .we    (wr_en && req_lane_en[l]),
      .re    (accept),
      .addr  (req_addr[ADDR_W-1:0]),
      .wdata (req_wdata[l*LANE_W +: LANE_W]),
      .rdata (bank_q[l*LANE_W +: LANE_W])
    );
  end

`ifdef DMEM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] par_q;
  logic [LANES-1:0] par_calc;

  // Parity storage follows the lane write enables; read alongside the lanes.
  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < LANES; l++) begin
      if (wr_en && req_lane_en[l])
        par_mem[req_addr[ADDR_W-1:0]][l] <= ^req_wdata[l*LANE_W +: LANE_W];
    end
    if (accept) par_q <= par_mem[req_addr[ADDR_W-1:0]];
  end

  // Recompute parity on the read data and flag any lane mismatch.
  always_comb begin
    par_calc = '0;
    for (int unsigned l = 0; l < LANES; l++)
      par_calc[l] = ^bank_q[l*LANE_W +: LANE_W];
    par_err = |(par_calc ^ par_q);
  end
`else
  assign par_err = 1'b0;
`endif

  // State, latency counter and captured request attributes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_store <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        is_store <= req_we;
        addr_err <= req_addr[ADDR_W];
      end
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_we || RD_LAT == 1) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = LAT_M1;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 3'd1;
        if (cnt == 3'd1) state_nx = RESP;
      end
      RESP: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Response outputs are decoded from state so reset clears them directly.
  always_comb begin
    resp_valid = (state == RESP);
    resp_rdata = (resp_valid && !is_store && !addr_err) ? bank_q : '0;
    resp_err   = resp_valid && (addr_err || (!is_store && par_err));
  end

endmodule

// File: tb/tb_vector_dmem_resp.sv
// Directed scoreboard bench for vector_dmem_resp.
module tb_vector_dmem_resp;

  localparam int ADDR_W = 10;
  localparam int RD_LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [10:0]  req_addr;
  logic [255:0] req_wdata;
  logic [7:0]   req_lane_en;
  logic         resp_valid;
  logic         resp_ready;
  logic [255:0] resp_rdata;
  logic         resp_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [255:0] rdata;
    logic         err;
  } exp_t;

  exp_t         sbq[$];
  logic [255:0] model [int];

  vector_dmem_resp #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_lane_en (req_lane_en),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: drive, predict, measure latency, optionally stall
  // the response for 'hold' cycles, then handshake and compare.
  task automatic xact(input logic we, input logic [10:0] addr, input logic [255:0] wd,
                      input logic [7:0] le, input int hold, input string tag);
    exp_t         e;
    exp_t         got;
    logic [255:0] cur;
    logic [255:0] keep_d;
    logic         keep_e;
    int           n;
    int           lat;
    int           a;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_lane_en = le;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, " accept"}, 256'(req_ready), 256'd1);
    a = int'(addr[9:0]);
    e.err = 1'b0;
    e.rdata = '0;
    if (addr[10]) begin
      e.err = 1'b1;
    end else if (we) begin
      cur = model.exists(a) ? model[a] : '0;
      for (int l = 0; l < 8; l++)
        if (le[l]) cur[l*32 +: 32] = wd[l*32 +: 32];
      model[a] = cur;
    end else begin
      e.rdata = model[a];
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = ~we;
    req_addr = 11'($urandom);
    req_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    req_lane_en = 8'($urandom);
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk({tag, " latency"}, 256'(lat), we ? 256'd1 : 256'(RD_LAT));
    keep_d = resp_rdata;
    keep_e = resp_err;
    for (int i = 0; i < hold; i++) begin
      chk({tag, " stall valid"}, 256'(resp_valid), 256'd1);
      chk({tag, " stall req_ready"}, 256'(req_ready), 256'd0);
      chk({tag, " stall rdata"}, resp_rdata, keep_d);
      chk({tag, " stall err"}, 256'(resp_err), 256'(keep_e));
      @(negedge clk);
    end
    chk({tag, " valid"}, 256'(resp_valid), 256'd1);
    resp_ready = 1'b1;
    got.rdata = resp_rdata;
    got.err = resp_err;
    e = sbq.pop_front();
    chk({tag, " rdata"}, got.rdata, e.rdata);
    chk({tag, " err"}, 256'(got.err), 256'(e.err));
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, " idle req_ready"}, 256'(req_ready), 256'd1);
    chk({tag, " idle valid"}, 256'(resp_valid), 256'd0);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] d;
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_lane_en = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset req_ready", 256'(req_ready), 256'd1);
    chk("reset valid", 256'(resp_valid), 256'd0);
    chk("reset rdata", resp_rdata, 256'd0);
    chk("reset err", 256'(resp_err), 256'd0);

    // Full store then load at address 5.
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'h1000 + 32'(i);
    xact(1'b1, 11'd5, d, 8'hFF, 0, "st5_full");
    xact(1'b0, 11'd5, '0, 8'h00, 0, "ld5_full");

    // Single-lane store only touches lane 0.
    xact(1'b1, 11'd5, {256{1'b1}}, 8'h01, 0, "st5_lane0");
    xact(1'b0, 11'd5, '0, 8'h00, 0, "ld5_lane0");

    // Stalled response.
    xact(1'b1, 11'd9, rnd256(), 8'hFF, 0, "st9");
    xact(1'b0, 11'd9, '0, 8'h00, 4, "ld9_stall");

    // Out-of-range load and store; store must not alias onto address 5.
    xact(1'b0, 11'h400, '0, 8'h00, 0, "ld_oor");
    xact(1'b1, 11'h405, rnd256(), 8'hFF, 1, "st_oor");
    xact(1'b0, 11'd5, '0, 8'h00, 0, "ld5_after_oor");

    // Mixed lane mask on address 0, top address boundary.
    xact(1'b1, 11'd0, rnd256(), 8'hFF, 0, "st0_full");
    xact(1'b1, 11'd0, rnd256(), 8'hA5, 2, "st0_mask");
    xact(1'b0, 11'd0, '0, 8'h00, 0, "ld0_mask");
    xact(1'b1, 11'h3FF, rnd256(), 8'hFF, 0, "st_top");
    xact(1'b0, 11'h3FF, '0, 8'h00, 0, "ld_top");

    // Reset during WAIT aborts the load.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'd9; req_lane_en = '0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("abort accept", 256'(req_ready), 256'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort in wait", 256'(resp_valid), 256'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort valid", 256'(resp_valid), 256'd0);
    rst = 1'b0;
    chk("abort req_ready", 256'(req_ready), 256'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort no resp", 256'(resp_valid), 256'd0);
    end

    // Memory survives reset.
    xact(1'b0, 11'd9, '0, 8'h00, 0, "ld9_post_rst");

`ifdef DMEM_PARITY_EN
    xact(1'b1, 11'd7, rnd256(), 8'hFF, 0, "st7_par");
    dut.g_lane[3].u_bank.mem[7][0] = ~dut.g_lane[3].u_bank.mem[7][0];
    model[7][3*32] = ~model[7][3*32];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'd7; req_lane_en = '0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    chk("par valid", 256'(resp_valid), 256'd1);
    chk("par err", 256'(resp_err), 256'd1);
    chk("par rdata", resp_rdata, model[7]);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
`endif

    chk("scoreboard empty", 256'(sbq.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
